// File: rtl/cmd_sequencer_if.sv
// ============================================================================
// Module   : cmd_sequencer_if
// Purpose  : Command, response and setpoint signal bundle for cmd_sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cmd_sequencer_if;
    logic               cmd_rdy;
    logic [7:0]         cmd;
    logic [15:0]        data;
    logic               clr_cmd_rdy;
    logic               send_resp;
    logic [7:0]         resp;
    logic               resp_sent;
    logic               cal_done;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic [8:0]         thrst;
    logic               strt_cal;
    logic               inertial_cal;
    logic               motors_off;

    // Sequencer side.
    modport master (
        input  cmd_rdy, cmd, data, resp_sent, cal_done,
        output clr_cmd_rdy, send_resp, resp, d_ptch, d_roll, d_yaw,
               thrst, strt_cal, inertial_cal, motors_off
    );

    // Receiver / transmitter / inertial side.
    modport slave (
        output cmd_rdy, cmd, data, resp_sent, cal_done,
        input  clr_cmd_rdy, send_resp, resp, d_ptch, d_roll, d_yaw,
               thrst, strt_cal, inertial_cal, motors_off
    );
endinterface

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// ============================================================================
// Module   : cmd_sequencer
// Purpose  : Decodes UART commands into flight setpoints, acknowledges each
//            command and zeroes the setpoints if commands stop arriving.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_sequencer #(
    parameter int TMO_BITS = 26,
    parameter int FAST_SIM = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    cmd_sequencer_if.master bus
);

    localparam int WD_BITS = (FAST_SIM != 0) ? 9 : TMO_BITS;

    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [7:0] RESP_ACK = 8'hA5;
    localparam logic [7:0] RESP_NAK = 8'hEE;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CAL_WAIT  = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_SENT = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic signed [15:0]   ptch_q, ptch_d;
    logic signed [15:0]   roll_q, roll_d;
    logic signed [15:0]   yaw_q, yaw_d;
    logic [8:0]           thrst_q, thrst_d;
    logic [7:0]           resp_q, resp_d;
    logic                 strt_cal_q, strt_cal_d;
    logic                 inertial_cal_q, inertial_cal_d;
    logic                 motors_off_q, motors_off_d;
    logic [WD_BITS-1:0]   wd_q, wd_d;

    logic                 w_accept;
    logic                 w_legal;
    logic                 w_wd_expire;

    assign w_accept    = (state_q == ST_IDLE) && bus.cmd_rdy;
    assign w_legal     = (bus.cmd >= OP_SET_PTCH) && (bus.cmd <= OP_MTRS_OFF);
    assign w_wd_expire = &wd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ptch_q         <= '0;
            roll_q         <= '0;
            yaw_q          <= '0;
            thrst_q        <= '0;
            resp_q         <= 8'h00;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
            motors_off_q   <= 1'b1;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            ptch_q         <= ptch_d;
            roll_q         <= roll_d;
            yaw_q          <= yaw_d;
            thrst_q        <= thrst_d;
            resp_q         <= resp_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
            motors_off_q   <= motors_off_d;
            wd_q           <= wd_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        ptch_d         = ptch_q;
        roll_d         = roll_q;
        yaw_d          = yaw_q;
        thrst_d        = thrst_q;
        resp_d         = resp_q;
        strt_cal_d     = 1'b0;
        inertial_cal_d = inertial_cal_q;
        motors_off_d   = motors_off_q;
        wd_d           = wd_q + {{(WD_BITS-1){1'b0}}, 1'b1};

        // A command arriving on the expiry cycle suppresses the zeroing entirely.
        if (w_wd_expire && !w_accept) begin
            ptch_d  = '0;
            roll_d  = '0;
            yaw_d   = '0;
            thrst_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    wd_d    = '0;
                    state_d = ST_SEND;
                    resp_d  = w_legal ? RESP_ACK : RESP_NAK;
                    case (bus.cmd)
                        OP_SET_PTCH:  ptch_d  = bus.data;
                        OP_SET_ROLL:  roll_d  = bus.data;
                        OP_SET_YAW:   yaw_d   = bus.data;
                        OP_SET_THRST: thrst_d = bus.data[8:0];
                        OP_CALIBRATE: begin
                            motors_off_d   = 1'b0;
                            strt_cal_d     = 1'b1;
                            inertial_cal_d = 1'b1;
                            state_d        = ST_CAL_WAIT;
                        end
                        OP_EMER_LAND: begin
                            ptch_d  = '0;
                            roll_d  = '0;
                            yaw_d   = '0;
                            thrst_d = '0;
                        end
                        OP_MTRS_OFF:  motors_off_d = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_CAL_WAIT: begin
                if (bus.cal_done) begin
                    inertial_cal_d = 1'b0;
                    state_d        = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (bus.resp_sent) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The consume pulse is combinational, so it must be masked while reset is held.
    assign bus.clr_cmd_rdy  = w_accept && !rst;
    assign bus.send_resp    = (state_q == ST_SEND);
    assign bus.resp         = resp_q;
    assign bus.d_ptch       = ptch_q;
    assign bus.d_roll       = roll_q;
    assign bus.d_yaw        = yaw_q;
    assign bus.thrst        = thrst_q;
    assign bus.strt_cal     = strt_cal_q;
    assign bus.inertial_cal = inertial_cal_q;
    assign bus.motors_off   = motors_off_q;

endmodule

`default_nettype wire
